mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between instruction fetch (IF) and the load/store unit (LS).
- Sits between the fetch stage / LSU and the unified memory.
- Drives the pipeline stall signals (StallF, StallM) for the hazard logic.
- One outstanding transaction at a time. LS has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and unified-memory handshakes of the memory port arbiter.
// No logic or latency; pure signal grouping.
// slave is the arbiter's view, master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // instruction fetch side
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              o_if_gnt;
   logic              o_if_rvalid;
   logic [DATA_W-1:0] o_if_rdata;

   // load/store side
   logic              i_ls_req;
   logic              i_ls_we;
   logic [BE_W-1:0]   i_ls_be;
   logic [ADDR_W-1:0] i_ls_addr;
   logic [DATA_W-1:0] i_ls_wdata;
   logic              o_ls_gnt;
   logic              o_ls_done;
   logic [DATA_W-1:0] o_ls_rdata;

   // unified memory side
   logic              o_mem_req;
   logic              o_mem_we;
   logic [BE_W-1:0]   o_mem_be;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_ready;
   logic              i_mem_rvalid;
   logic [DATA_W-1:0] i_mem_rdata;

   // hazard unit and error reporting
   logic              o_stall_f;
   logic              o_stall_m;
   logic              o_err;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
      output o_ls_gnt, o_ls_done, o_ls_rdata,
      output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
      output o_stall_f, o_stall_m, o_err
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
      input  o_ls_gnt, o_ls_done, o_ls_rdata,
      input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      output i_mem_ready, i_mem_rvalid, i_mem_rdata,
      input  o_stall_f, o_stall_m, o_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between fetch and load/store, LS first with IF anti-starvation.
// Latency: request cycle 0 -> o_mem_req cycle 1 -> read data earliest cycle 2; one transaction outstanding.
// Backpressure: memory request held stable until i_mem_ready; requesters stall until done. Macro ARB_TIMEOUT_EN adds a response watchdog.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int STARVE_MAX  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

   state_t            state, state_nxt;
   owner_t            owner, owner_nxt;
   logic [3:0]        starve_cnt, starve_nxt;
   logic              mem_we, mem_we_nxt;
   logic [BE_W-1:0]   mem_be, mem_be_nxt;
   logic [ADDR_W-1:0] mem_addr, mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata, mem_wdata_nxt;

   logic              mem_req;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_gnt, ls_done;
   logic [DATA_W-1:0] ls_rdata;
   logic              err;
   logic              tmo_hit;
   logic              pick_if, pick_ls;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] tmo_cnt;

   // Watchdog counts cycles spent in REQ/WAIT_RD, restarting on every state change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt <= '0;
      end else if (state_nxt != state) begin
         tmo_cnt <= '0;
      end else if (state != IDLE) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Last permitted cycle of the current state has been reached.
   always_comb begin
      tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
   end
`else
   // Without the watchdog the FSM waits on the memory indefinitely.
   always_comb begin
      tmo_hit = 1'b0;
   end
`endif

   // State, ownership, starvation counter and latched memory command.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         starve_cnt <= starve_nxt;
         mem_we     <= mem_we_nxt;
         mem_be     <= mem_be_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
      end
   end

   // Arbitration, next-state and per-cycle handshake outputs.
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      starve_nxt    = starve_cnt;
      mem_we_nxt    = mem_we;
      mem_be_nxt    = mem_be;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_req       = 1'b0;
      if_gnt        = 1'b0;
      if_rvalid     = 1'b0;
      if_rdata      = '0;
      ls_gnt        = 1'b0;
      ls_done       = 1'b0;
      ls_rdata      = '0;
      err           = 1'b0;
      // IF is forced ahead only when it has watched STARVE_MAX LS grants go by.
      pick_if       = bus.i_if_req && (!bus.i_ls_req || (starve_cnt == STARVE_LIM));
      pick_ls       = bus.i_ls_req && !pick_if;

      case (state)
         IDLE: begin
            if (!bus.i_if_req) begin
               starve_nxt = '0;
            end
            if (pick_if) begin
               owner_nxt     = OWN_IF;
               mem_we_nxt    = 1'b0;
               mem_be_nxt    = '1;
               mem_addr_nxt  = bus.i_if_addr;
               mem_wdata_nxt = '0;
               state_nxt     = REQ;
            end else if (pick_ls) begin
               owner_nxt     = OWN_LS;
               mem_we_nxt    = bus.i_ls_we;
               mem_be_nxt    = bus.i_ls_be;
               mem_addr_nxt  = bus.i_ls_addr;
               mem_wdata_nxt = bus.i_ls_wdata;
               state_nxt     = REQ;
            end
         end

         REQ: begin
            mem_req = 1'b1;
            if (bus.i_mem_ready) begin
               if (owner == OWN_IF) begin
                  if_gnt     = 1'b1;
                  starve_nxt = '0;
                  state_nxt  = WAIT_RD;
               end else begin
                  ls_gnt = 1'b1;
                  if (bus.i_if_req && (starve_cnt != STARVE_LIM)) begin
                     starve_nxt = starve_cnt + 4'd1;
                  end
                  if (mem_we) begin
                     // A store completes as soon as the memory takes it.
                     ls_done   = bus.i_ls_req;
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = WAIT_RD;
                  end
               end
            end else if (tmo_hit) begin
               err = 1'b1;
               if (owner == OWN_IF) begin
                  if_rvalid = bus.i_if_req;
               end else begin
                  ls_done = bus.i_ls_req;
               end
               state_nxt = IDLE;
            end
         end

         WAIT_RD: begin
            if (bus.i_mem_rvalid) begin
               // Responses for a requester that has already dropped its req are discarded.
               if (owner == OWN_IF) begin
                  if_rvalid = bus.i_if_req;
                  if_rdata  = bus.i_if_req ? bus.i_mem_rdata : '0;
               end else begin
                  ls_done  = bus.i_ls_req;
                  ls_rdata = bus.i_ls_req ? bus.i_mem_rdata : '0;
               end
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               err = 1'b1;
               if (owner == OWN_IF) begin
                  if_rvalid = bus.i_if_req;
               end else begin
                  ls_done = bus.i_ls_req;
               end
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.o_mem_req   = mem_req;
   assign bus.o_mem_we    = mem_we;
   assign bus.o_mem_be    = mem_be;
   assign bus.o_mem_addr  = mem_addr;
   assign bus.o_mem_wdata = mem_wdata;
   assign bus.o_if_gnt    = if_gnt;
   assign bus.o_if_rvalid = if_rvalid;
   assign bus.o_if_rdata  = if_rdata;
   assign bus.o_ls_gnt    = ls_gnt;
   assign bus.o_ls_done   = ls_done;
   assign bus.o_ls_rdata  = ls_rdata;
   assign bus.o_err       = err;
   assign bus.o_stall_f   = bus.i_if_req & ~if_rvalid;
   assign bus.o_stall_m   = bus.i_ls_req & ~ls_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: IF read, LS/IF contention, starvation, ready backpressure, reset, watchdog.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
// Each check is an immediate assertion that counts passes and reports failures.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   nchk;
   int   npass;
   int   n_ls;
   int   n_gnt;
   int   if_at;
   bit   seen_if;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      nchk  = 0;
      npass = 0;
      rst   = 1'b1;
      bus.i_if_req     = 1'b0;
      bus.i_if_addr    = '0;
      bus.i_ls_req     = 1'b0;
      bus.i_ls_we      = 1'b0;
      bus.i_ls_be      = '0;
      bus.i_ls_addr    = '0;
      bus.i_ls_wdata   = '0;
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = '0;

      // reset state
      tick();
      tick();
      #1;
      chk("rst_mem_req", bus.o_mem_req, 0);
      chk("rst_mem_addr", bus.o_mem_addr, 0);
      chk("rst_if_gnt", bus.o_if_gnt, 0);
      chk("rst_ls_done", bus.o_ls_done, 0);
      chk("rst_err", bus.o_err, 0);
      tick();
      rst = 1'b0;

      // IF-only read of 0x100, ready immediately
      tick();
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h100; bus.i_mem_ready = 1'b1;
      #1;
      chk("t1_c0_stall_f", bus.o_stall_f, 1);
      chk("t1_c0_mem_req", bus.o_mem_req, 0);
      tick();
      #1;
      chk("t1_c1_mem_req", bus.o_mem_req, 1);
      chk("t1_c1_mem_addr", bus.o_mem_addr, 32'h100);
      chk("t1_c1_mem_we", bus.o_mem_we, 0);
      chk("t1_c1_mem_be", bus.o_mem_be, 4'hF);
      chk("t1_c1_if_gnt", bus.o_if_gnt, 1);
      chk("t1_c1_stall_f", bus.o_stall_f, 1);
      tick();
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h13;
      #1;
      chk("t1_c2_if_rvalid", bus.o_if_rvalid, 1);
      chk("t1_c2_if_rdata", bus.o_if_rdata, 32'h13);
      chk("t1_c2_stall_f", bus.o_stall_f, 0);
      chk("t1_c2_mem_req", bus.o_mem_req, 0);
      chk("t1_c2_if_gnt", bus.o_if_gnt, 0);
      tick();
      bus.i_if_req = 1'b0; bus.i_mem_rvalid = 1'b0;
      #1;
      chk("t1_c3_if_rvalid", bus.o_if_rvalid, 0);
      chk("t1_c3_if_rdata", bus.o_if_rdata, 0);

      // simultaneous IF read and LS store: LS first
      tick();
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h104;
      bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1; bus.i_ls_be = 4'hF;
      bus.i_ls_addr = 32'h2000; bus.i_ls_wdata = 32'hDEADBEEF;
      #1;
      chk("t2_c0_stall_f", bus.o_stall_f, 1);
      chk("t2_c0_stall_m", bus.o_stall_m, 1);
      tick();
      #1;
      chk("t2_c1_mem_addr", bus.o_mem_addr, 32'h2000);
      chk("t2_c1_mem_we", bus.o_mem_we, 1);
      chk("t2_c1_mem_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
      chk("t2_c1_ls_gnt", bus.o_ls_gnt, 1);
      chk("t2_c1_ls_done", bus.o_ls_done, 1);
      chk("t2_c1_stall_m", bus.o_stall_m, 0);
      chk("t2_c1_if_gnt", bus.o_if_gnt, 0);
      tick();
      bus.i_ls_req = 1'b0;
      #1;
      chk("t2_c2_mem_req", bus.o_mem_req, 0);
      tick();
      #1;
      chk("t2_c3_mem_addr", bus.o_mem_addr, 32'h104);
      chk("t2_c3_mem_we", bus.o_mem_we, 0);
      chk("t2_c3_if_gnt", bus.o_if_gnt, 1);
      tick();
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hA5A5;
      #1;
      chk("t2_c4_if_rvalid", bus.o_if_rvalid, 1);
      chk("t2_c4_if_rdata", bus.o_if_rdata, 32'hA5A5);
      tick();
      bus.i_if_req = 1'b0; bus.i_mem_rvalid = 1'b0;

      // continuous LS stores with IF waiting: 4 LS grants then IF
      n_ls = 0; if_at = -1; seen_if = 1'b0;
      tick();
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h108;
      bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1;
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h55;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bus.o_ls_gnt && !seen_if) n_ls++;
         if (bus.o_if_gnt && !seen_if) begin
            seen_if = 1'b1;
            if_at   = c;
         end
         tick();
      end
      chk("t3_ls_grants", 64'(n_ls), 4);
      chk("t3_if_gnt_cycle", 64'(if_at), 9);
      #1;
      chk("t3_if_rvalid", bus.o_if_rvalid, 1);
      chk("t3_if_rdata", bus.o_if_rdata, 32'h55);
      chk("t3_starve_cnt", dut.starve_cnt, 0);
      tick();
      bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0; bus.i_mem_rvalid = 1'b0;

      // ready held low 5 cycles in REQ for an LS load
      tick();
      bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_be = 4'h3;
      bus.i_ls_addr = 32'h3000; bus.i_mem_ready = 1'b0;
      n_gnt = 0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         #1;
         chk("t4_hold_mem_req", bus.o_mem_req, 1);
         chk("t4_hold_mem_addr", bus.o_mem_addr, 32'h3000);
         chk("t4_hold_mem_we", bus.o_mem_we, 0);
         if (bus.o_ls_gnt) n_gnt++;
      end
      tick();
      bus.i_mem_ready = 1'b1;
      #1;
      chk("t4_c6_mem_be", bus.o_mem_be, 4'h3);
      if (bus.o_ls_gnt) n_gnt++;
      tick();
      bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h12345678;
      #1;
      if (bus.o_ls_gnt) n_gnt++;
      chk("t4_gnt_pulses", 64'(n_gnt), 1);
      chk("t4_c7_mem_req", bus.o_mem_req, 0);
      chk("t4_c7_ls_done", bus.o_ls_done, 1);
      chk("t4_c7_ls_rdata", bus.o_ls_rdata, 32'h12345678);
      chk("t4_c7_err", bus.o_err, 0);
      tick();
      bus.i_ls_req = 1'b0; bus.i_mem_rvalid = 1'b0;

      // reset asserted in WAIT_RD, stray rvalid afterwards, then clean restart
      tick();
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h200; bus.i_mem_ready = 1'b1;
      tick();
      #1;
      chk("t5_c1_if_gnt", bus.o_if_gnt, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_mem_addr", bus.o_mem_addr, 0);
      chk("t5_rst_if_rvalid", bus.o_if_rvalid, 0);
      tick();
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hBAD;
      #1;
      chk("t5_rst_stray_rvalid", bus.o_if_rvalid, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("t5_idle_stray_rvalid", bus.o_if_rvalid, 0);
      chk("t5_idle_stray_rdata", bus.o_if_rdata, 0);
      tick();
      #1;
      chk("t5_restart_mem_req", bus.o_mem_req, 1);
      chk("t5_restart_mem_addr", bus.o_mem_addr, 32'h200);
      chk("t5_restart_if_gnt", bus.o_if_gnt, 1);
      chk("t5_restart_no_rvalid", bus.o_if_rvalid, 0);
      tick();
      bus.i_mem_rdata = 32'h77;
      #1;
      chk("t5_restart_if_rvalid", bus.o_if_rvalid, 1);
      chk("t5_restart_if_rdata", bus.o_if_rdata, 32'h77);
      tick();
      bus.i_if_req = 1'b0; bus.i_mem_rvalid = 1'b0;

`ifdef ARB_TIMEOUT_EN
      // read response never returns: watchdog completes LS with zero data
      tick();
      bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_addr = 32'h4000;
      bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'hFFFF;
      tick();
      #1;
      chk("t6_ls_gnt", bus.o_ls_gnt, 1);
      for (int c = 2; c <= 8; c++) begin
         tick();
         #1;
         chk("t6_wait_err", bus.o_err, 0);
         chk("t6_wait_ls_done", bus.o_ls_done, 0);
      end
      tick();
      #1;
      chk("t6_err_pulse", bus.o_err, 1);
      chk("t6_ls_done", bus.o_ls_done, 1);
      chk("t6_ls_rdata", bus.o_ls_rdata, 0);
      tick();
      bus.i_ls_req = 1'b0;
      #1;
      chk("t6_idle_err", bus.o_err, 0);
      chk("t6_idle_mem_req", bus.o_mem_req, 0);
      chk("t6_idle_state", dut.state, 0);
`endif

      tick();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
